// File: rtl/clut_cache_fill.sv
// clut_cache_fill: multi-port palette (CLUT) cache. Lookups hit only on fully filled blocks;
// a miss in IDLE launches one block fetch (REQ -> FILL) from memory, two colors per word.
module clut_cache_fill #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 8,
    parameter int BLK_W     = 4
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [14:0]                i_clutId,
    input  logic                       i_invalidate,
    input  logic [NUM_PORTS-1:0]       i_requ,
    input  logic [NUM_PORTS*IDX_W-1:0] i_readIdx,
    output logic [NUM_PORTS-1:0]       o_hit,
    output logic [NUM_PORTS-1:0]       o_miss,
    output logic [NUM_PORTS*16-1:0]    o_color,
    output logic [NUM_PORTS-1:0]       o_colorValid,
    output logic                       o_memReq,
    output logic [14:0]                o_memClut,
    output logic [IDX_W-BLK_W-1:0]     o_memBlock,
    input  logic                       i_memAck,
    input  logic                       i_memValid,
    input  logic [31:0]                i_memData,
    output logic                       o_busy
);
    localparam int BLKIDX_W   = IDX_W - BLK_W;
    localparam int NUM_BLOCKS = 1 << BLKIDX_W;
    localparam int CNT_W      = BLK_W - 1;
    localparam int ADDR_W     = IDX_W - 1;
    localparam int NUM_WORDS  = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t                state;
    logic [NUM_BLOCKS-1:0] valid;
    logic [CNT_W-1:0]      cnt;
    logic                  aborted;
    logic [14:0]           clut_q;
    logic [31:0]           mem [NUM_WORDS];

    logic                  clear_now;
    logic [BLKIDX_W-1:0]   miss_block;

    assign clear_now = i_invalidate || (clut_q != i_clutId);
    assign o_busy    = (state != IDLE);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [IDX_W-1:0]    idx;
        logic [BLKIDX_W-1:0] blk;
        logic [31:0]         word;
        logic [15:0]         color_q;
        logic                color_valid_q;

        assign idx  = i_readIdx[p*IDX_W +: IDX_W];
        assign blk  = idx[IDX_W-1 -: BLKIDX_W];
        assign word = mem[idx[IDX_W-1:1]];

        assign o_hit[p]            = i_requ[p] & valid[blk];
        assign o_miss[p]           = i_requ[p] & ~valid[blk];
        assign o_color[p*16 +: 16] = color_q;
        assign o_colorValid[p]     = color_valid_q;

        always_ff @(posedge clk) begin
            if (i_rst) begin
                color_q       <= '0;
                color_valid_q <= 1'b0;
            end else begin
                color_q       <= idx[0] ? word[31:16] : word[15:0];
                color_valid_q <= o_hit[p];
            end
        end
    end

    // Lowest-numbered missing port wins the fetch.
    always_comb begin
        miss_block = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (o_miss[p]) miss_block = i_readIdx[p*IDX_W + BLK_W +: BLKIDX_W];
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= IDLE;
            valid      <= '0;
            cnt        <= '0;
            aborted    <= 1'b0;
            clut_q     <= '0;
            o_memReq   <= 1'b0;
            o_memClut  <= '0;
            o_memBlock <= '0;
        end else begin
            clut_q <= i_clutId;
            if (clear_now) valid <= '0;
            case (state)
                IDLE: begin
                    if (|o_miss) begin
                        o_memReq   <= 1'b1;
                        o_memClut  <= i_clutId;
                        o_memBlock <= miss_block;
                        aborted    <= 1'b0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (clear_now) aborted <= 1'b1;
                    if (i_memAck) begin
                        o_memReq <= 1'b0;
                        cnt      <= '0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (clear_now) aborted <= 1'b1;
                    if (i_memValid) begin
                        cnt <= cnt + 1'b1;
                        if (&cnt) begin
                            // A clear in the last-word cycle also aborts, so it never races the set.
                            if (!aborted && !clear_now) valid[o_memBlock] <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: storage has no reset; its contents only matter behind a set valid bit.
    always_ff @(posedge clk) begin
        if (!i_rst && state == FILL && i_memValid) mem[{o_memBlock, cnt}] <= i_memData;
    end

endmodule

// File: tb/tb_clut_cache_fill.sv
// Self-checking bench for clut_cache_fill: directed fill sequences, a lookup vector table,
// and a per-port color scoreboard fed at hit time and drained on o_colorValid.
module tb_clut_cache_fill;
    localparam int NP = 2;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [14:0]   i_clutId;
    logic          i_invalidate;
    logic [NP-1:0] i_requ;
    logic [NP*IW-1:0] i_readIdx;
    logic [NP-1:0] o_hit;
    logic [NP-1:0] o_miss;
    logic [NP*16-1:0] o_color;
    logic [NP-1:0] o_colorValid;
    logic          o_memReq;
    logic [14:0]   o_memClut;
    logic [3:0]    o_memBlock;
    logic          i_memAck;
    logic          i_memValid;
    logic [31:0]   i_memData;
    logic          o_busy;

    always #5 clk = ~clk;

    clut_cache_fill #(.NUM_PORTS(NP), .IDX_W(IW), .BLK_W(4)) dut (
        .clk(clk), .i_rst(i_rst), .i_clutId(i_clutId), .i_invalidate(i_invalidate),
        .i_requ(i_requ), .i_readIdx(i_readIdx), .o_hit(o_hit), .o_miss(o_miss),
        .o_color(o_color), .o_colorValid(o_colorValid), .o_memReq(o_memReq),
        .o_memClut(o_memClut), .o_memBlock(o_memBlock), .i_memAck(i_memAck),
        .i_memValid(i_memValid), .i_memData(i_memData), .o_busy(o_busy)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] model_mem [128];
    logic [15:0] exp_q [NP][$];

    typedef struct packed {
        logic [1:0] requ;
        logic [7:0] idx0;
        logic [7:0] idx1;
        logic [1:0] exp_hit;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_color(input logic [7:0] idx);
        logic [31:0] w;
        w = model_mem[idx[7:1]];
        return idx[0] ? w[31:16] : w[15:0];
    endfunction

    task automatic push_hits(input logic [NP-1:0] ports);
        for (int p = 0; p < NP; p++)
            if (ports[p]) exp_q[p].push_back(exp_color(i_readIdx[p*IW +: IW]));
    endtask

    // Scoreboard drain: every registered color must match the oldest expectation for its port.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (o_colorValid[p]) begin
                    if (exp_q[p].size() == 0) begin
                        check($sformatf("unexpected_color_p%0d", p), 32'(o_colorValid[p]), 0);
                    end else begin
                        e = exp_q[p].pop_front();
                        check($sformatf("color_p%0d", p), 32'(o_color[p*16 +: 16]), 32'(e));
                    end
                end
            end
        end
    end

    // Serves one block fetch; starts and ends just after a rising edge.
    task automatic serve_fill(input logic [3:0] blk, input logic [14:0] clut,
                              input logic [31:0] base, input logic [31:0] step,
                              input int abort_at, input logic [14:0] new_clut, input int probe);
        bit got;
        logic [31:0] d;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_memReq) begin
                got = 1;
                break;
            end
            cyc();
        end
        check("req_seen", 32'(got), 1);
        if (!got) begin
            cyc();
            return;
        end
        check("req_block", 32'(o_memBlock), 32'(blk));
        check("req_clut", 32'(o_memClut), 32'(clut));
        check("busy_in_req", 32'(o_busy), 1);
        cyc();
        i_memValid = 1'b1;
        i_memData  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("req_held", 32'({o_memReq, o_memBlock}), 32'({1'b1, blk}));
        cyc();
        i_memValid = 1'b0;
        i_memAck   = 1'b1;
        cyc();
        i_memAck = 1'b0;
        @(negedge clk);
        check("req_dropped_on_ack", 32'(o_memReq), 0);
        check("busy_in_fill", 32'(o_busy), 1);
        cyc();
        for (int n = 0; n < 8; n++) begin
            d = base + 32'(n) * step;
            i_memValid = 1'b1;
            i_memData  = d;
            model_mem[{blk, 3'(n)}] = d;
            if (n == abort_at) i_clutId = new_clut;
            if (n == 7 && probe >= 0) begin
                @(negedge clk);
                check("last_word_no_hit", 32'(o_hit[probe]), 0);
            end
            cyc();
            i_memValid = 1'b0;
            if (n == 3) cyc();
        end
        if (probe >= 0) begin
            @(negedge clk);
            check("hit_after_fill", 32'(o_hit[probe]), 1);
            exp_q[probe].push_back(exp_color(i_readIdx[probe*IW +: IW]));
            cyc();
            i_requ = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'b11, 8'h00, 8'h9F, 2'b11};
        vecs[1] = '{2'b01, 8'h2E, 8'h00, 2'b01};
        vecs[2] = '{2'b10, 8'h00, 8'h21, 2'b10};
        vecs[3] = '{2'b00, 8'h05, 8'h95, 2'b00};
        vecs[4] = '{2'b11, 8'h0A, 8'h0A, 2'b11};
        vecs[5] = '{2'b11, 8'h9C, 8'h2F, 2'b11};
        vecs[6] = '{2'b11, 8'h91, 8'h90, 2'b11};

        i_rst = 1'b1; i_clutId = 15'h0040; i_invalidate = 1'b0; i_requ = '0;
        i_readIdx = '0; i_memAck = 1'b0; i_memValid = 1'b0; i_memData = '0;
        cyc();
        cyc();
        @(negedge clk);
        check("rst_memReq", 32'(o_memReq), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_colorValid", 32'(o_colorValid), 0);
        check("rst_color", 32'(o_color), 0);
        check("rst_memClut_block", 32'({o_memClut, o_memBlock}), 0);
        cyc();
        i_rst = 1'b0;
        cyc();

        // First miss: idx 0x23 lives in block 2.
        i_requ = 2'b01; i_readIdx = {8'h00, 8'h23};
        @(negedge clk);
        check("first_miss", 32'({o_hit, o_miss}), 32'(4'b0001));
        cyc();
        i_requ = '0;
        serve_fill(4'd2, 15'h0040, 32'h1111_0000, 32'd1, -1, 15'h0, -1);
        i_requ = 2'b01; i_readIdx = {8'h00, 8'h23};
        @(negedge clk);
        check("hit_0x23", 32'(o_hit), 32'(2'b01));
        push_hits(2'b01);
        check("model_0x23", 32'(exp_color(8'h23)), 32'h1111);
        cyc();
        i_requ = '0;

        // Two ports miss together: block 0 first, then block 9.
        i_requ = 2'b11; i_readIdx = {8'h95, 8'h05};
        @(negedge clk);
        check("dual_miss", 32'(o_miss), 32'(2'b11));
        cyc();
        i_requ = 2'b10;
        serve_fill(4'd0, 15'h0040, 32'hA0A0_0B0B, 32'h0001_0001, -1, 15'h0, -1);
        serve_fill(4'd9, 15'h0040, 32'h9C00_3900, 32'h0001_0001, -1, 15'h0, 1);
        i_requ = 2'b11; i_readIdx = {8'h95, 8'h05};
        @(negedge clk);
        check("dual_hit", 32'(o_hit), 32'(2'b11));
        push_hits(2'b11);
        cyc();
        i_requ = '0;

        // Lookup table against blocks 0, 2, 9; stray memValid in IDLE must be ignored.
        i_memValid = 1'b1; i_memData = 32'hBAD0_BAD0;
        for (int v = 0; v < 7; v++) begin
            i_requ = vecs[v].requ;
            i_readIdx = {vecs[v].idx1, vecs[v].idx0};
            @(negedge clk);
            check($sformatf("vec%0d_hit", v), 32'(o_hit), 32'(vecs[v].exp_hit));
            check($sformatf("vec%0d_miss", v), 32'(o_miss), 32'(vecs[v].requ & ~vecs[v].exp_hit));
            push_hits(vecs[v].exp_hit);
            cyc();
        end
        i_requ = '0; i_memValid = 1'b0;
        cyc();

        // CLUT change mid-fill: transfer completes, block stays invalid, refetch uses new CLUT.
        i_requ = 2'b01; i_readIdx = {8'h00, 8'h47};
        cyc();
        serve_fill(4'd4, 15'h0040, 32'h4444_0000, 32'h0001_0001, 3, 15'h0041, -1);
        @(negedge clk);
        check("abort_still_miss", 32'({o_hit, o_miss}), 32'(4'b0001));
        check("abort_idle", 32'(o_busy), 0);
        cyc();
        serve_fill(4'd4, 15'h0041, 32'h4747_1000, 32'h0002_0003, -1, 15'h0, 0);
        i_requ = 2'b10; i_readIdx = {8'h05, 8'h00};
        @(negedge clk);
        check("clut_change_cleared", 32'(o_miss), 32'(2'b10));
        cyc();
        i_requ = '0;
        serve_fill(4'd0, 15'h0041, 32'h0C0C_0D0D, 32'h0001_0001, -1, 15'h0, -1);

        // Invalidate pulse, then reset in the middle of the refetch.
        i_invalidate = 1'b1;
        cyc();
        i_invalidate = 1'b0;
        i_requ = 2'b01; i_readIdx = {8'h00, 8'h47};
        @(negedge clk);
        check("invalidate_miss", 32'({o_hit, o_miss}), 32'(4'b0001));
        cyc();
        i_requ = '0;
        @(negedge clk);
        check("refetch_req", 32'({o_memReq, o_memClut, o_memBlock}), 32'({1'b1, 15'h0041, 4'd4}));
        cyc();
        i_memAck = 1'b1;
        cyc();
        i_memAck = 1'b0;
        for (int n = 0; n < 4; n++) begin
            i_memValid = 1'b1; i_memData = 32'h5555_0000 + 32'(n);
            cyc();
        end
        i_memValid = 1'b1; i_rst = 1'b1;
        cyc();
        i_memValid = 1'b0;
        @(negedge clk);
        check("rst_fill_memReq", 32'(o_memReq), 0);
        check("rst_fill_busy", 32'(o_busy), 0);
        i_requ = 2'b11; i_readIdx = {8'h47, 8'h05};
        #1;
        check("rst_all_miss", 32'({o_hit, o_miss}), 32'(4'b0011));
        cyc();
        i_rst = 1'b0; i_requ = '0;

        repeat (3) cyc();
        check("scoreboard_drained", 32'(exp_q[0].size() + exp_q[1].size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
